// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the data-memory access path: op sizes, access FSM states
// and byte-enable patterns.
package riscv_mem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam logic [3:0] MASK_NONE    = 4'b0000;
   localparam logic [3:0] MASK_BYTE0   = 4'b0001;
   localparam logic [3:0] MASK_HALF_LO = 4'b0011;
   localparam logic [3:0] MASK_HALF_HI = 4'b1100;
   localparam logic [3:0] MASK_WORD    = 4'b1111;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational store lane replication, byte-enable generation and alignment check.
// Zero latency; no flow control. Size 2'b11 is handled as a word.
module store_lane_gen
   import riscv_mem_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_rs2,
   output logic [31:0] o_wdata,
   output logic [3:0]  o_wmask,
   output logic        o_aligned
);

   always_comb begin
      o_wdata   = i_rs2;
      o_wmask   = MASK_WORD;
      o_aligned = (i_addr == 2'b00);
      case (i_size)
         SZ_BYTE: begin
            o_wdata   = {4{i_rs2[7:0]}};
            o_wmask   = MASK_BYTE0 << i_addr;
            o_aligned = 1'b1;
         end
         SZ_HALF: begin
            o_wdata   = {2{i_rs2[15:0]}};
            o_wmask   = i_addr[1] ? MASK_HALF_HI : MASK_HALF_LO;
            o_aligned = ~i_addr[0];
         end
         default: begin
            o_wdata   = i_rs2;
            o_wmask   = MASK_WORD;
            o_aligned = (i_addr == 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store issue to data memory with req/ack handshake and timeout abort.
// Accept to done_out is 2+ cycles; stall_out holds the pipeline from accept until done/abort.
module dmem_access_unit
   import riscv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 5
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        valid_in,
   input  logic        is_load_in,
   input  logic        is_store_in,
   input  logic [1:0]  size_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   output logic        stall_out,
   output logic        dm_req_out,
   output logic        dm_we_out,
   output logic [31:0] dm_addr_out,
   output logic [31:0] dm_wdata_out,
   output logic [3:0]  dm_wmask_out,
   input  logic        dm_ack_in,
   input  logic [31:0] dm_rdata_in,
   output logic [31:0] dmdata_out,
   output logic [1:0]  iadder_1_0_out,
   output logic        done_out,
   output logic        misaligned_out,
   output logic        bus_err_out
);

   localparam bit              LP_TO_EN    = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(LP_TO_EN ? TIMEOUT_CYCLES - 1 : 0);

   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_is_load;
   logic              r_req;
   logic              r_we;
   logic [31:0]       r_addr;
   logic [31:0]       r_wdata;
   logic [3:0]        r_wmask;
   logic [31:0]       r_dmdata;
   logic [1:0]        r_a10;
   logic              r_done;
   logic              r_misal;
   logic              r_berr;

   logic [31:0]       w_wdata;
   logic [3:0]        w_wmask;
   logic              w_aligned;
   logic              w_op;
   logic              w_start;
   logic              w_misal;
   logic              w_timeout;
   logic              w_ack_done;
   logic              w_abort;

   store_lane_gen u_lane (
      .i_size    (size_in),
      .i_addr    (iadder_in[1:0]),
      .i_rs2     (rs2_in),
      .o_wdata   (w_wdata),
      .o_wmask   (w_wmask),
      .o_aligned (w_aligned)
   );

   assign w_op      = valid_in & (is_load_in | is_store_in);
   assign w_start   = (r_state == ST_IDLE) & w_op & w_aligned;
   assign w_misal   = (r_state == ST_IDLE) & w_op & ~w_aligned;
   assign w_timeout = LP_TO_EN & (r_cnt == LP_CNT_LAST);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // An ack in the final timeout cycle still completes the access.
   always_comb begin
      w_state_nxt = r_state;
      w_ack_done  = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (dm_ack_in) begin
               w_state_nxt = ST_IDLE;
               w_ack_done  = 1'b1;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_abort     = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_cnt     <= '0;
         r_is_load <= 1'b0;
         r_req     <= 1'b0;
         r_we      <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wmask   <= '0;
         r_dmdata  <= '0;
         r_a10     <= '0;
         r_done    <= 1'b0;
         r_misal   <= 1'b0;
         r_berr    <= 1'b0;
      end else begin
         r_done  <= w_ack_done;
         r_misal <= w_misal;
         r_berr  <= w_abort;
         r_cnt   <= (LP_TO_EN && r_state == ST_BUSY && w_state_nxt == ST_BUSY) ? r_cnt + 1'b1 : '0;

         // Request fields stay frozen after completion; only req itself drops.
         if (w_start) begin
            r_req     <= 1'b1;
            r_we      <= is_store_in;
            r_addr    <= {iadder_in[31:2], 2'b00};
            r_wdata   <= w_wdata;
            r_wmask   <= is_store_in ? w_wmask : MASK_NONE;
            r_a10     <= iadder_in[1:0];
            r_is_load <= ~is_store_in;
         end else if (w_ack_done || w_abort) begin
            r_req <= 1'b0;
         end

         if (w_ack_done && r_is_load) begin
            r_dmdata <= dm_rdata_in;
         end
      end
   end

   assign stall_out      = (r_state == ST_BUSY) | w_start;
   assign dm_req_out     = r_req;
   assign dm_we_out      = r_we;
   assign dm_addr_out    = r_addr;
   assign dm_wdata_out   = r_wdata;
   assign dm_wmask_out   = r_wmask;
   assign dmdata_out     = r_dmdata;
   assign iadder_1_0_out = r_a10;
   assign done_out       = r_done;
   assign misaligned_out = r_misal;
   assign bus_err_out    = r_berr;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed stimulus for dmem_access_unit; expected events go into a queue that a
// negedge monitor pops whenever the DUT raises req, done, misaligned or bus error.
module tb_dmem_access_unit;

   localparam int unsigned TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_in, is_load_in, is_store_in;
   logic [1:0]  size_in;
   logic [31:0] iadder_in, rs2_in;
   logic        stall_out, dm_req_out, dm_we_out;
   logic [31:0] dm_addr_out, dm_wdata_out;
   logic [3:0]  dm_wmask_out;
   logic        dm_ack_in;
   logic [31:0] dm_rdata_in;
   logic [31:0] dmdata_out;
   logic [1:0]  iadder_1_0_out;
   logic        done_out, misaligned_out, bus_err_out;

   always #5 clk = ~clk;

   dmem_access_unit #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk_in         (clk),
      .rst_in         (rst_n),
      .valid_in       (valid_in),
      .is_load_in     (is_load_in),
      .is_store_in    (is_store_in),
      .size_in        (size_in),
      .iadder_in      (iadder_in),
      .rs2_in         (rs2_in),
      .stall_out      (stall_out),
      .dm_req_out     (dm_req_out),
      .dm_we_out      (dm_we_out),
      .dm_addr_out    (dm_addr_out),
      .dm_wdata_out   (dm_wdata_out),
      .dm_wmask_out   (dm_wmask_out),
      .dm_ack_in      (dm_ack_in),
      .dm_rdata_in    (dm_rdata_in),
      .dmdata_out     (dmdata_out),
      .iadder_1_0_out (iadder_1_0_out),
      .done_out       (done_out),
      .misaligned_out (misaligned_out),
      .bus_err_out    (bus_err_out)
   );

   typedef enum int {K_REQ, K_DONE, K_MIS, K_BERR} kind_e;
   typedef struct {
      kind_e       k;
      int          cyc;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] dm;
      logic [1:0]  a10;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   stall_cnt = 0;
   int   req_cnt = 0;
   int   done_cnt = 0;
   logic prev_req = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (stall_out)  stall_cnt++;
      if (dm_req_out) req_cnt++;
      if (done_out)   done_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input kind_e k, input int c, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wmask,
                       input logic [31:0] dm, input logic [1:0] a10);
      exp_t e;
      e.k = k; e.cyc = c; e.we = we; e.addr = addr; e.wdata = wdata;
      e.wmask = wmask; e.dm = dm; e.a10 = a10;
      sb.push_back(e);
   endtask

   task automatic handle(input kind_e k);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL unexpected_%s actual=1 expected=0 (cycle %0d)", k.name(), cyc);
      end else begin
         e = sb.pop_front();
         chk("event_kind", k, e.k);
         chk("event_cycle", cyc, e.cyc);
         case (k)
            K_REQ: begin
               chk("req_we", dm_we_out, e.we);
               chk("req_addr", dm_addr_out, e.addr);
               chk("req_wdata", dm_wdata_out, e.wdata);
               chk("req_wmask", dm_wmask_out, e.wmask);
            end
            K_DONE: begin
               chk("done_dmdata", dmdata_out, e.dm);
               chk("done_a10", iadder_1_0_out, e.a10);
            end
            K_MIS: begin
               chk("mis_dmdata", dmdata_out, e.dm);
               chk("mis_a10", iadder_1_0_out, e.a10);
            end
            default: chk("berr_dmdata", dmdata_out, e.dm);
         endcase
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (dm_req_out && !prev_req) handle(K_REQ);
         if (done_out)                handle(K_DONE);
         if (misaligned_out)          handle(K_MIS);
         if (bus_err_out)             handle(K_BERR);
      end
      prev_req = dm_req_out;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic ld, input logic st, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] d, output int t0);
      tick();
      valid_in = 1'b1; is_load_in = ld; is_store_in = st;
      size_in = sz; iadder_in = a; rs2_in = d;
      t0 = cyc;
      stall_cnt = 0;
      req_cnt = 0;
      tick();
      valid_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
   endtask

   task automatic ack_after(input int n, input logic [31:0] rd);
      repeat (n - 1) tick();
      dm_ack_in = 1'b1;
      dm_rdata_in = rd;
      tick();
      dm_ack_in = 1'b0;
      dm_rdata_in = 32'h0BAD0BAD;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_req"}, dm_req_out, 0);
      chk({tag, "_we"}, dm_we_out, 0);
      chk({tag, "_addr"}, dm_addr_out, 0);
      chk({tag, "_wdata"}, dm_wdata_out, 0);
      chk({tag, "_wmask"}, dm_wmask_out, 0);
      chk({tag, "_dmdata"}, dmdata_out, 0);
      chk({tag, "_a10"}, iadder_1_0_out, 0);
      chk({tag, "_done"}, done_out, 0);
      chk({tag, "_mis"}, misaligned_out, 0);
      chk({tag, "_berr"}, bus_err_out, 0);
      chk({tag, "_stall"}, stall_out, 0);
   endtask

   initial begin
      int t0;
      int d0;
      rst_n = 1'b1;
      valid_in = 1'b0; is_load_in = 1'b0; is_store_in = 1'b0;
      size_in = 2'b00; iadder_in = '0; rs2_in = '0;
      dm_ack_in = 1'b0; dm_rdata_in = 32'h0BAD0BAD;
      #1 rst_n = 1'b0;
      #2 check_all_zero("reset");
      #19 rst_n = 1'b1;

      // word load, ack on the 3rd busy cycle
      issue(1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'h0, t0);
      push(K_REQ, t0 + 1, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'h0, 2'd0);
      push(K_DONE, t0 + 4, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'd0);
      ack_after(3, 32'hDEAD_BEEF);
      tick();
      chk("load_stall_cycles", stall_cnt, 4);

      // byte store at 0x2003, immediate ack; rdata must not reach dmdata
      issue(1'b0, 1'b1, 2'b00, 32'h0000_2003, 32'h0000_00A5, t0);
      push(K_REQ, t0 + 1, 1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 4'b1000, 32'h0, 2'd0);
      push(K_DONE, t0 + 2, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'd3);
      ack_after(1, 32'h1111_1111);
      tick();
      chk("bstore_stall_cycles", stall_cnt, 2);

      // half store at 0x3002
      issue(1'b0, 1'b1, 2'b01, 32'h0000_3002, 32'h0000_1234, t0);
      push(K_REQ, t0 + 1, 1'b1, 32'h0000_3000, 32'h1234_1234, 4'b1100, 32'h0, 2'd0);
      push(K_DONE, t0 + 3, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'd2);
      ack_after(2, 32'h2222_2222);
      tick();

      // misaligned half load at 0x3001
      issue(1'b1, 1'b0, 2'b01, 32'h0000_3001, 32'h0, t0);
      push(K_MIS, t0 + 1, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'd2);
      tick();
      tick();
      chk("mis_req_cycles", req_cnt, 0);
      chk("mis_stall_cycles", stall_cnt, 0);

      // timeout: no ack, req high exactly TO cycles
      issue(1'b1, 1'b0, 2'b10, 32'h0000_4000, 32'h0, t0);
      push(K_REQ, t0 + 1, 1'b0, 32'h0000_4000, 32'h0, 4'h0, 32'h0, 2'd0);
      push(K_BERR, t0 + 5, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'd0);
      repeat (5) tick();
      chk("timeout_req_cycles", req_cnt, TO);

      // ack in the last timeout cycle wins
      issue(1'b1, 1'b0, 2'b10, 32'h0000_4004, 32'h0, t0);
      push(K_REQ, t0 + 1, 1'b0, 32'h0000_4004, 32'h0, 4'h0, 32'h0, 2'd0);
      push(K_DONE, t0 + 5, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 2'd0);
      ack_after(4, 32'hCAFE_F00D);
      tick();
      tick();

      // more lane patterns
      issue(1'b0, 1'b1, 2'b01, 32'h0000_5000, 32'hABCD_9876, t0);
      push(K_REQ, t0 + 1, 1'b1, 32'h0000_5000, 32'h9876_9876, 4'b0011, 32'h0, 2'd0);
      push(K_DONE, t0 + 2, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 2'd0);
      ack_after(1, 32'h3333_3333);
      tick();

      issue(1'b0, 1'b1, 2'b00, 32'h0000_5001, 32'h0000_003C, t0);
      push(K_REQ, t0 + 1, 1'b1, 32'h0000_5000, 32'h3C3C_3C3C, 4'b0010, 32'h0, 2'd0);
      push(K_DONE, t0 + 2, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 2'd1);
      ack_after(1, 32'h3333_3333);
      tick();

      // load and store both set behaves as a store
      issue(1'b1, 1'b1, 2'b10, 32'h0000_8000, 32'h0102_0304, t0);
      push(K_REQ, t0 + 1, 1'b1, 32'h0000_8000, 32'h0102_0304, 4'b1111, 32'h0, 2'd0);
      push(K_DONE, t0 + 2, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFE_F00D, 2'd0);
      ack_after(1, 32'h4444_4444);
      tick();

      // size 11 load acts as word
      issue(1'b1, 1'b0, 2'b11, 32'h0000_7000, 32'h0, t0);
      push(K_REQ, t0 + 1, 1'b0, 32'h0000_7000, 32'h0, 4'h0, 32'h0, 2'd0);
      push(K_DONE, t0 + 3, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1357_9BDF, 2'd0);
      ack_after(2, 32'h1357_9BDF);
      tick();

      issue(1'b1, 1'b0, 2'b10, 32'h0000_7002, 32'h0, t0);
      push(K_MIS, t0 + 1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h1357_9BDF, 2'd0);
      tick();
      tick();
      chk("wmis_req_cycles", req_cnt, 0);

      // valid without load or store does nothing
      issue(1'b0, 1'b0, 2'b10, 32'h0000_7100, 32'h0, t0);
      tick();
      tick();
      chk("nop_req_cycles", req_cnt, 0);
      chk("nop_stall_cycles", stall_cnt, 0);

      // asynchronous reset in the middle of BUSY, late ack ignored
      issue(1'b1, 1'b0, 2'b10, 32'h0000_9000, 32'h0, t0);
      push(K_REQ, t0 + 1, 1'b0, 32'h0000_9000, 32'h0, 4'h0, 32'h0, 2'd0);
      tick();
      #2 rst_n = 1'b0;
      #1 check_all_zero("midrst");
      d0 = done_cnt;
      #4 rst_n = 1'b1;
      tick();
      dm_ack_in = 1'b1;
      dm_rdata_in = 32'h7777_7777;
      tick();
      dm_ack_in = 1'b0;
      tick();
      tick();
      chk("late_ack_done", done_cnt, d0);
      chk("late_ack_dmdata", dmdata_out, 32'h0);

      // back-to-back word loads with valid held
      tick();
      valid_in = 1'b1; is_load_in = 1'b1; is_store_in = 1'b0;
      size_in = 2'b10; iadder_in = 32'h0000_A000; rs2_in = '0;
      t0 = cyc;
      push(K_REQ, t0 + 1, 1'b0, 32'h0000_A000, 32'h0, 4'h0, 32'h0, 2'd0);
      push(K_DONE, t0 + 2, 1'b0, 32'h0, 32'h0, 4'h0, 32'h55AA_55AA, 2'd0);
      push(K_REQ, t0 + 3, 1'b0, 32'h0000_A004, 32'h0, 4'h0, 32'h0, 2'd0);
      push(K_DONE, t0 + 4, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0F0F_0F0F, 2'd0);
      tick();
      iadder_in = 32'h0000_A004;
      dm_ack_in = 1'b1; dm_rdata_in = 32'h55AA_55AA;
      tick();
      dm_ack_in = 1'b0; dm_rdata_in = 32'h0BAD0BAD;
      tick();
      valid_in = 1'b0; is_load_in = 1'b0;
      dm_ack_in = 1'b1; dm_rdata_in = 32'h0F0F_0F0F;
      tick();
      dm_ack_in = 1'b0; dm_rdata_in = 32'h0BAD0BAD;
      repeat (3) tick();

      chk("scoreboard_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
